// File: rtl/select_way_plru.sv
// Tree pseudo-LRU victim selector, one PLRU tree per set.
// Invalid ways win over the tree. A same-cycle touch to the looked-up set is
// visible to that lookup. The victim outputs are registered.
// Optional feature: define REPL_LOCK_EN to add lock_mask, which excludes ways from replacement.
module select_way_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 8,
  localparam int LW = $clog2(WAYS),
  localparam int LS = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [LS-1:0]   lookup_set,
  input  logic [WAYS-1:0] valid_bits,
  input  logic            touch_valid,
  input  logic [LS-1:0]   touch_set,
  input  logic [LW-1:0]   touch_way,
`ifdef REPL_LOCK_EN
  input  logic [WAYS-1:0] lock_mask,
`endif
  output logic            victim_valid,
  output logic [WAYS-1:0] victim_onehot,
  output logic [LW-1:0]   victim_idx
);

  // Heap node k lives at bit WAYS-2-k. A node value of 1 steers the walk to the lower half.
  logic [WAYS-2:0] tree_q [SETS];
  logic [WAYS-2:0] tree_d [SETS];
  logic [WAYS-2:0] touched_tree;
  logic [WAYS-2:0] lookup_tree;
  logic [WAYS-1:0] eff_lock;
  logic [WAYS-1:0] cand;
  logic [LW-1:0]   inv_idx;
  logic [LW-1:0]   sel_idx;

  logic            victim_valid_q, victim_valid_d;
  logic [WAYS-1:0] victim_onehot_q, victim_onehot_d;
  logic [LW-1:0]   victim_idx_q, victim_idx_d;

  // Point every node on the path to w away from w. The prefix of w at depth d picks the node.
  function automatic logic [WAYS-2:0] apply_touch(input logic [WAYS-2:0] t,
                                                  input logic [LW-1:0]   w);
    logic [WAYS-2:0] r;
    int node;
    r = t;
    for (int d = 0; d < LW; d++) begin
      node = (1 << d) - 1 + int'(w >> (LW - d));
      r[WAYS-2-node] = w[LW-1-d];
    end
    return r;
  endfunction

  // Walk the tree from the root. Step around any subtree in which every way is locked.
  function automatic logic [LW-1:0] walk(input logic [WAYS-2:0] t,
                                         input logic [WAYS-1:0] lk);
    int   p;
    int   node;
    logic go_low;
    logic low_locked;
    logic high_locked;
    p = 0;
    for (int d = 0; d < LW; d++) begin
      node = (1 << d) - 1 + p;
      go_low = t[WAYS-2-node];
      low_locked = 1'b1;
      high_locked = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if ((w >> (LW - 1 - d)) == (p << 1)) low_locked = low_locked & lk[w];
        if ((w >> (LW - 1 - d)) == ((p << 1) + 1)) high_locked = high_locked & lk[w];
      end
      if (go_low && low_locked) go_low = 1'b0;
      else if (!go_low && high_locked) go_low = 1'b1;
      p = (p << 1) + (go_low ? 0 : 1);
    end
    return LW'(p);
  endfunction

  // Updated tree for the touched set; the lookup sees it when both requests name the same set.
  always_comb begin
    touched_tree = apply_touch(tree_q[touch_set], touch_way);
    if (touch_valid && (touch_set == lookup_set)) lookup_tree = touched_tree;
    else lookup_tree = tree_q[lookup_set];
  end

  // Effective lock mask. When every way is locked, the mask is dropped for this lookup.
  always_comb begin
`ifdef REPL_LOCK_EN
    eff_lock = (&lock_mask) ? '0 : lock_mask;
`else
    eff_lock = '0;
`endif
  end

  // Victim choice: the lowest unlocked invalid way first, otherwise the tree walk.
  always_comb begin
    cand = valid_bits ^ {WAYS{1'b1}};
    cand = cand & ~eff_lock;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (cand[w]) inv_idx = LW'(w);
    end
    sel_idx = (|cand) ? inv_idx : walk(lookup_tree, eff_lock);
  end

  // Next state of the victim outputs. The index and one-hot hold between lookups.
  always_comb begin
    victim_valid_d  = lookup_valid;
    victim_idx_d    = victim_idx_q;
    victim_onehot_d = victim_onehot_q;
    if (lookup_valid) begin
      victim_idx_d    = sel_idx;
      victim_onehot_d = WAYS'(1) << sel_idx;
    end
  end

  // Victim output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_valid_q  <= 1'b0;
      victim_onehot_q <= WAYS'(1);
      victim_idx_q    <= '0;
    end else begin
      victim_valid_q  <= victim_valid_d;
      victim_onehot_q <= victim_onehot_d;
      victim_idx_q    <= victim_idx_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_set
      // Only the touched set takes the updated tree.
      always_comb begin
        tree_d[gi] = tree_q[gi];
        if (touch_valid && (touch_set == LS'(gi))) tree_d[gi] = touched_tree;
      end

      // Per-set tree state. Reset sets all bits to 1, so the first all-valid victim is way 0.
      always_ff @(posedge clk) begin
        if (rst) tree_q[gi] <= '1;
        else     tree_q[gi] <= tree_d[gi];
      end
    end
  endgenerate

  assign victim_valid  = victim_valid_q;
  assign victim_onehot = victim_onehot_q;
  assign victim_idx    = victim_idx_q;

endmodule

// File: tb/tb_select_way_plru.sv
// Bench for select_way_plru (WAYS=4, SETS=8): directed cases, then random traffic.
// The reference model is a heap-indexed node array walked with parent/child arithmetic.
module tb_select_way_plru;
  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       lookup_valid;
  logic [2:0] lookup_set;
  logic [3:0] valid_bits;
  logic       touch_valid;
  logic [2:0] touch_set;
  logic [1:0] touch_way;
  logic [3:0] lock_mask;
  logic       victim_valid;
  logic [3:0] victim_onehot;
  logic [1:0] victim_idx;

  int n_checks = 0;
  int n_fail = 0;

  // Node value 1 means the victim lies in the lower-index subtree.
  int plru [SETS][WAYS-1];
  int exp_valid;
  int exp_idx;

  select_way_plru #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set), .valid_bits(valid_bits),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
`ifdef REPL_LOCK_EN
    .lock_mask(lock_mask),
`endif
    .victim_valid(victim_valid), .victim_onehot(victim_onehot), .victim_idx(victim_idx)
  );

  always #5 clk = ~clk;

  function automatic bit subtree_locked(int n, logic [3:0] lk);
    int lo;
    int hi;
    bit all;
    lo = n;
    hi = n;
    while (lo < WAYS - 1) begin
      lo = 2 * lo + 1;
      hi = 2 * hi + 2;
    end
    all = 1'b1;
    for (int l = lo; l <= hi; l++) all = all & lk[l-(WAYS-1)];
    return all;
  endfunction

  function automatic int model_victim(int s, logic [3:0] vb, logic [3:0] lk_in);
    logic [3:0] lk;
    int node;
    int lo;
    int hi;
    bit go_lo;
    lk = (lk_in == 4'hF) ? 4'h0 : lk_in;
    for (int w = 0; w < WAYS; w++) if (!vb[w] && !lk[w]) return w;
    node = 0;
    while (node < WAYS - 1) begin
      lo = 2 * node + 1;
      hi = 2 * node + 2;
      go_lo = (plru[s][node] == 1);
      if (go_lo && subtree_locked(lo, lk)) go_lo = 1'b0;
      else if (!go_lo && subtree_locked(hi, lk)) go_lo = 1'b1;
      node = go_lo ? lo : hi;
    end
    return node - (WAYS - 1);
  endfunction

  function automatic void model_touch(int s, int w);
    int leaf;
    int parent;
    leaf = w + WAYS - 1;
    while (leaf > 0) begin
      parent = (leaf - 1) / 2;
      plru[s][parent] = (leaf == 2 * parent + 1) ? 0 : 1;
      leaf = parent;
    end
  endfunction

  task automatic chk(string tag, int obs, int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the model, clock, then compare the registered outputs.
  task automatic step(string tag, bit r, bit lv, int ls, logic [3:0] vb,
                      bit tv, int ts, int tw, logic [3:0] lk);
    logic [3:0] lk_eff;
    rst = r; lookup_valid = lv; lookup_set = 3'(ls); valid_bits = vb;
    touch_valid = tv; touch_set = 3'(ts); touch_way = 2'(tw); lock_mask = lk;
`ifdef REPL_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 4'h0;
`endif
    if (r) begin
      for (int s = 0; s < SETS; s++) for (int k = 0; k < WAYS - 1; k++) plru[s][k] = 1;
      exp_valid = 0;
      exp_idx = 0;
    end else begin
      if (tv) model_touch(ts, tw);
      exp_valid = lv ? 1 : 0;
      if (lv) exp_idx = model_victim(ls, vb, lk_eff);
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, int'(victim_valid), exp_valid);
    chk({tag, ".idx"}, int'(victim_idx), exp_idx);
    chk({tag, ".onehot"}, int'(victim_onehot), 1 << exp_idx);
  endtask

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_set = '0; valid_bits = '1;
    touch_valid = 1'b0; touch_set = '0; touch_way = '0; lock_mask = '0;
    exp_valid = 0; exp_idx = 0;

    step("reset", 1, 0, 0, 4'hF, 0, 0, 0, 4'h0);
    step("reset2", 1, 1, 3, 4'hF, 1, 3, 2, 4'h0);
    step("first_lookup", 0, 1, 3, 4'hF, 0, 0, 0, 4'h0);
    chk("first_lookup.fixed_idx", int'(victim_idx), 0);
    step("idle_hold", 0, 0, 0, 4'hF, 0, 0, 0, 4'h0);

    step("touch_s3w0", 0, 0, 0, 4'hF, 1, 3, 0, 4'h0);
    step("lookup_s3", 0, 1, 3, 4'hF, 0, 0, 0, 4'h0);
    chk("lookup_s3.fixed_idx", int'(victim_idx), 2);
    step("touch_s1w2", 0, 0, 0, 4'hF, 1, 1, 2, 4'h0);
    step("lookup_s3_again", 0, 1, 3, 4'hF, 0, 0, 0, 4'h0);
    chk("lookup_s3_again.fixed_idx", int'(victim_idx), 2);
    step("invalid_1011", 0, 1, 3, 4'b1011, 0, 0, 0, 4'h0);
    chk("invalid_1011.fixed_idx", int'(victim_idx), 2);
    step("invalid_1110", 0, 1, 3, 4'b1110, 0, 0, 0, 4'h0);
    chk("invalid_1110.fixed_idx", int'(victim_idx), 0);

    step("rst_again", 1, 0, 0, 4'hF, 0, 0, 0, 4'h0);
    step("bypass", 0, 1, 3, 4'hF, 1, 3, 0, 4'h0);
    chk("bypass.fixed_idx", int'(victim_idx), 2);
    step("lookup_in_rst", 1, 1, 3, 4'hF, 0, 0, 0, 4'h0);
    chk("lookup_in_rst.fixed_valid", int'(victim_valid), 0);

`ifdef REPL_LOCK_EN
    step("lk_touch", 0, 0, 0, 4'hF, 1, 3, 0, 4'h0);
    step("lock_0100", 0, 1, 3, 4'hF, 0, 0, 0, 4'b0100);
    chk("lock_0100.fixed_idx", int'(victim_idx), 3);
    step("lock_1111", 0, 1, 3, 4'hF, 0, 0, 0, 4'b1111);
    chk("lock_1111.fixed_idx", int'(victim_idx), 2);
`endif

    for (int i = 0; i < 12; i++) step("pre_touch", 0, 0, 0, 4'hF, 1, $urandom_range(0, 7), $urandom_range(0, 3), 4'h0);
    for (int s = 0; s < 8; s++) step("b2b", 0, 1, s, 4'hF, 0, 0, 0, 4'h0);
    step("b2b_end", 0, 0, 0, 4'hF, 0, 0, 0, 4'h0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] vb;
      vb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step("rand", ($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 7), vb,
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/select_way_plru.md
SELECT_WAY_PLRU -- requirements
Module: select_way_plru

Interface
REQ-001 Parameter WAYS, default 4, meaning associativity; SHALL be a power of two, 2..16.
REQ-002 Parameter SETS, default 8, meaning number of sets tracked; SHALL be a power of two, 2..256.
REQ-003 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-004 Port list SHALL be (name direction width meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- lookup_valid  in  1  victim request
- lookup_set  in  log2(SETS)  set being requested
- valid_bits  in  WAYS  valid bit of each way of lookup_set
- touch_valid  in  1  hit/fill update request
- touch_set  in  log2(SETS)  set being updated
- touch_way  in  log2(WAYS)  way hit or filled
- lock_mask  in  WAYS  ways excluded from replacement (present only with REPL_LOCK_EN)
- victim_valid  out  1  victim outputs valid this cycle
- victim_onehot  out  WAYS  one-hot victim way
- victim_idx  out  log2(WAYS)  binary victim way

Function
REQ-005 Per set, the block SHALL hold a tree pseudo-LRU vector of WAYS-1 bits; heap node k (children 2k+1, 2k+2) SHALL be stored at bit WAYS-2-k.
REQ-006 Node bit 1 SHALL point the victim walk to the lower-index half; 0 SHALL point to the upper half.
REQ-007 On touch_valid, every node on the path to touch_way SHALL be written to point away from touch_way; off-path bits SHALL be unchanged.
REQ-008 If any valid_bits bit is 0, the victim SHALL be the lowest-index invalid way, regardless of tree state.
REQ-009 If all valid_bits are 1, the victim SHALL be the leaf reached by walking the tree from the root.
REQ-010 Victim outputs SHALL be registered: victim_valid SHALL be 1 exactly one cycle after each lookup_valid cycle and 0 otherwise.
REQ-011 Back-to-back lookups SHALL be accepted every cycle with no stall.
REQ-012 When victim_valid is 0, victim_onehot and victim_idx SHALL hold their last values.
REQ-013 victim_onehot SHALL always have exactly one bit set, and victim_idx SHALL always be its binary encoding.
REQ-014 When touch and lookup target the same set in the same cycle, the lookup SHALL use the tree as updated by that touch.
REQ-015 A touch SHALL NOT modify the tree of any other set.
REQ-016 A lookup SHALL NOT modify any tree state.

Reset
REQ-017 On rst, every tree bit in every set SHALL be set to 1, so the first all-valid victim is way 0.
REQ-018 On rst, victim_valid SHALL be 0, victim_onehot SHALL be 1 (way 0), and victim_idx SHALL be 0.
REQ-019 A lookup or touch in a cycle where rst is 1 SHALL be discarded, giving victim_valid 0 in the following cycle.

Configuration
REQ-020 With macro REPL_LOCK_EN defined, lock_mask SHALL exist and locked ways SHALL be excluded from replacement as follows:
- Invalid-way priority SHALL consider only unlocked ways.
- At each tree node, if the indicated subtree is fully locked, the walk SHALL take the other subtree.
- If all ways are locked, lock_mask SHALL be ignored for that lookup.
REQ-021 Without REPL_LOCK_EN, the lock_mask port SHALL be absent and behaviour SHALL be exactly REQ-005..REQ-019.

Verification (WAYS=4, SETS=8)
REQ-022 Reset, then lookup set 3 with valid_bits 4'b1111 -> next cycle victim_valid 1, victim_idx 0, victim_onehot 4'b0001.
REQ-023 After reset, touch set 3 way 0, then lookup set 3 with all valid -> victim_idx 2; touch set 1 way 2, then lookup set 3 -> still victim_idx 2.
REQ-024 Lookup with valid_bits 4'b1011 -> victim_idx 2; with 4'b1110 -> victim_idx 0, independent of tree state.
REQ-025 After reset, touch set 3 way 0 and lookup set 3 (all valid) in the same cycle -> victim_idx 2; lookup with rst high in that cycle -> victim_valid 0 next cycle.
REQ-026 With REPL_LOCK_EN, after reset and touch set 3 way 0:
- lock_mask 4'b0100, all valid -> victim_idx 3.
- lock_mask 4'b1111 -> victim_idx 2.
REQ-027 Lookups on 8 consecutive cycles (sets 0..7) -> victim_valid held at 1 for 8 cycles, each result matching its set.
